dense_out_block: RTL and testbench

Output-side counterpart of the embedding lookup: takes one hidden vector of `HID_DIM` signed fixed-point words and returns the character index whose weight row gives the largest dot product with it (linear projection plus argmax). It sits at the end of the dense datapath and turns a `HID_DIM*N_LEN` vector back into a `CHAR_LEN`-bit character code. Weights stream from an internal synchronous ROM, `DATA_N` words per cycle.

---
 rtl/dense_out_block.sv | 146 ++++++++++++++
 tb/tb_dense_out_block.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dense_out_block.sv
// dense_out_block: projects a latched hidden vector onto CHAR_NUM weight rows streamed
// from an internal ROM and returns the index of the row with the largest dot product.
module dense_out_rom #(
    parameter int DEPTH = 800,
    parameter int WIDTH = 96,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] q
);
    // contents are preloaded from the hex weight image when the design is built
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        q <= mem[addr];
endmodule

module dense_out_block #(
    parameter int CHAR_NUM = 200,
    parameter int CHAR_LEN = 8,
    parameter int HID_DIM  = 24,
    parameter int DATA_N   = 6,
    parameter int N_LEN    = 16,
    parameter int ADDR_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [HID_DIM*N_LEN-1:0]  d,
    output logic                      valid,
    output logic [CHAR_LEN-1:0]       q
);
    localparam int N_CH   = HID_DIM / DATA_N;
    localparam int N_ADDR = CHAR_NUM * N_CH;
    localparam int CH_W   = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int ACC_W  = 2 * N_LEN + $clog2(HID_DIM);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [HID_DIM*N_LEN-1:0]   d_reg;
    logic [ADDR_W-1:0]          addr;
    logic [DATA_N*N_LEN-1:0]    w;
    logic                       dv;
    logic [CH_W-1:0]            chunk;
    logic [CHAR_LEN-1:0]        row;
    logic [CHAR_LEN-1:0]        best_idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    best_score;
    logic signed [ACC_W-1:0]    partial;
    logic signed [ACC_W-1:0]    score;
    logic signed [N_LEN-1:0]    dw;
    logic signed [N_LEN-1:0]    ww;
    logic signed [2*N_LEN-1:0]  prod;
    logic                       last_chunk;
    logic                       last_row;
    logic                       better;

    dense_out_rom #(.DEPTH(N_ADDR), .WIDTH(DATA_N*N_LEN), .AW(ADDR_W)) u_rom (
        .clk  (clk),
        .addr (addr),
        .q    (w)
    );

    always_comb begin
        partial = '0;
        dw      = '0;
        ww      = '0;
        prod    = '0;
        for (int i = 0; i < DATA_N; i++) begin
            dw      = d_reg[(int'(chunk) * DATA_N + i) * N_LEN +: N_LEN];
            ww      = w[i * N_LEN +: N_LEN];
            prod    = (2*N_LEN)'(dw) * (2*N_LEN)'(ww);
            partial = partial + ACC_W'(prod);
        end
        score      = chunk == '0 ? partial : acc + partial;
        last_chunk = chunk == CH_W'(N_CH - 1);
        last_row   = row == CHAR_LEN'(CHAR_NUM - 1);
        // strict compare keeps the lowest index on ties; row 0 always seeds the best
        better     = row == '0 || score > best_score;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= 1'b0;
            q          <= '0;
            addr       <= '0;
            acc        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            d_reg      <= '0;
            dv         <= 1'b0;
            chunk      <= '0;
            row        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    dv    <= 1'b0;
                    if (run) begin
                        d_reg <= d;
                        addr  <= '0;
                        chunk <= '0;
                        row   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                        dv    <= 1'b0;
                    end else begin
                        addr <= addr == ADDR_W'(N_ADDR - 1) ? addr : addr + 1'b1;
                        // dv marks that the ROM output holds a fetched chunk
                        dv   <= 1'b1;
                        if (dv) begin
                            acc   <= score;
                            chunk <= last_chunk ? '0 : chunk + 1'b1;
                            if (last_chunk) begin
                                row <= row + 1'b1;
                                if (better) begin
                                    best_score <= score;
                                    best_idx   <= row;
                                end
                                if (last_row) begin
                                    q     <= better ? row : best_idx;
                                    valid <= 1'b1;
                                    state <= DONE;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (!run) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_out_block.sv
// tb_dense_out_block: randomized and directed argmax runs checked against a plain dot-product model.
module tb_dense_out_block;
    localparam int CN = 200;
    localparam int HD = 24;
    localparam int DN = 6;
    localparam int NL = 16;
    localparam int NCH = HD / DN;
    localparam int NA = CN * NCH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic [HD*NL-1:0] d = '0;
    logic             valid;
    logic [7:0]       q;

    int n_chk = 0;
    int n_err = 0;

    logic signed [NL-1:0] w_ref [CN][HD];
    logic signed [NL-1:0] d_ref [HD];

    dense_out_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .d     (d),
        .valid (valid),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model();
        longint best = 0;
        int idx = 0;
        for (int c = 0; c < CN; c++) begin
            longint s = 0;
            for (int k = 0; k < HD; k++)
                s += longint'(d_ref[k]) * longint'(w_ref[c][k]);
            if (c == 0 || s > best) begin
                best = s;
                idx = c;
            end
        end
        return idx;
    endfunction

    task automatic load();
        logic [DN*NL-1:0] word;
        for (int c = 0; c < CN; c++)
            for (int j = 0; j < NCH; j++) begin
                for (int i = 0; i < DN; i++)
                    word[i*NL +: NL] = w_ref[c][j*DN + i];
                dut.u_rom.mem[c*NCH + j] = word;
            end
        for (int k = 0; k < HD; k++)
            d[k*NL +: NL] = d_ref[k];
    endtask

    task automatic fill(input logic signed [NL-1:0] wv, input logic signed [NL-1:0] dv);
        for (int c = 0; c < CN; c++)
            for (int k = 0; k < HD; k++)
                w_ref[c][k] = wv;
        for (int k = 0; k < HD; k++)
            d_ref[k] = dv;
    endtask

    task automatic fill_rand();
        for (int c = 0; c < CN; c++)
            for (int k = 0; k < HD; k++)
                w_ref[c][k] = NL'($urandom());
        for (int k = 0; k < HD; k++)
            d_ref[k] = NL'($urandom());
    endtask

    task automatic run_op(input string tag, input int exp);
        load();
        @(negedge clk) run = 1'b1;
        @(posedge clk);
        #1 d = {12{$urandom()}};
        repeat (NA) @(posedge clk);
        #1 check({tag, "_pre801_valid"}, valid, 0);
        @(posedge clk);
        #1 check({tag, "_valid"}, valid, 1);
        check({tag, "_q"}, q, exp);
        repeat (3) @(posedge clk);
        #1 check({tag, "_hold_valid"}, valid, 1);
        check({tag, "_hold_q"}, q, exp);
        @(negedge clk) run = 1'b0;
        @(posedge clk);
        #1 check({tag, "_drop_valid"}, valid, 0);
        check({tag, "_drop_q"}, q, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check("reset_valid", valid, 0);
        check("reset_q", q, 0);
        @(negedge clk) rst_n = 1'b1;

        fill(0, 16'sh0100);
        w_ref[37][5] = 16'sh0100;
        run_op("onehot", 37);

        load();
        @(negedge clk) run = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", valid, 0);
        check("async_rst_q", q, 0);
        run = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("post_rst_valid", valid, 0);

        run_op("onehot2", 37);

        fill(16'sh8000, 16'sh7fff);
        for (int k = 0; k < HD; k++)
            w_ref[10][k] = 16'sh7fff;
        load();
        @(negedge clk) run = 1'b1;
        repeat (301) @(posedge clk);
        @(negedge clk) run = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("abort_valid", valid, 0);
        check("abort_q", q, 37);
        run_op("abort_rerun", 10);

        fill_rand();
        for (int k = 0; k < HD; k++)
            d_ref[k] = 0;
        run_op("tie", 0);

        fill_rand();
        for (int k = 0; k < HD; k++)
            d_ref[k] = 0;
        d_ref[0] = -16'sd1;
        for (int c = 0; c < CN; c++)
            w_ref[c][0] = NL'(-c);
        run_op("signed", 199);

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_op($sformatf("rand%0d", r), model());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
